// File: rtl/rtc_pkg.sv
// Shared constants and calendar helpers for the BCD real-time clock.
package rtc_pkg;

  localparam logic [3:0] ADDR_SEC    = 4'h0;
  localparam logic [3:0] ADDR_MIN    = 4'h1;
  localparam logic [3:0] ADDR_HOUR   = 4'h2;
  localparam logic [3:0] ADDR_DAY    = 4'h3;
  localparam logic [3:0] ADDR_DATE   = 4'h4;
  localparam logic [3:0] ADDR_MONTH  = 4'h5;
  localparam logic [3:0] ADDR_YEAR   = 4'h6;
  localparam logic [3:0] ADDR_CTRL   = 4'h7;
  localparam logic [3:0] ADDR_ASEC   = 4'h8;
  localparam logic [3:0] ADDR_AMIN   = 4'h9;
  localparam logic [3:0] ADDR_AHOUR  = 4'hA;
  localparam logic [3:0] ADDR_STATUS = 4'hB;

  localparam int CTRL_HALT   = 0;
  localparam int CTRL_MODE12 = 1;
  localparam int CTRL_AIE    = 2;
  localparam int STATUS_AF   = 0;

  localparam logic [6:0] RST_SEC   = 7'h00;
  localparam logic [6:0] RST_MIN   = 7'h00;
  localparam logic [5:0] RST_HOUR  = 6'h00;
  localparam logic [2:0] RST_DAY   = 3'd1;
  localparam logic [5:0] RST_DATE  = 6'h01;
  localparam logic [4:0] RST_MONTH = 5'h01;
  localparam logic [7:0] RST_YEAR  = 8'h00;
  localparam logic [2:0] RST_CTRL  = 3'b000;

  // Two-digit BCD increment; caller handles the field-specific wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  // (10*tens + units) mod 4 == (2*tens + units) mod 4; year 00 counts as leap.
  function automatic logic is_leap(input logic [7:0] year_bcd);
    logic [1:0] rem;
    rem = year_bcd[1:0] + {year_bcd[4], 1'b0};
    return (rem == 2'd0);
  endfunction

  function automatic logic [5:0] days_in_month(input logic [4:0] month_bcd,
                                               input logic [7:0] year_bcd);
    case (month_bcd)
      5'h04, 5'h06, 5'h09, 5'h11: return 6'h30;
      5'h02:                      return is_leap(year_bcd) ? 6'h29 : 6'h28;
      default:                    return 6'h31;
    endcase
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV cycles; freezes on halt.
module rtc_prescaler #(
  parameter int CLK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic halt_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A tick still fires when a clear lands on the wrap cycle; the counter restarts either way.
  assign tick_o = !halt_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (halt_i) begin
      cnt_d = cnt_q;
    end else if (cnt_q >= LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_core.sv
// BCD calendar clock with alarm and a byte-wide register interface.
module rtc_core
  import rtc_pkg::*;
#(
  parameter int CLK_DIV  = 100000000,
  parameter int ALARM_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i2c_addr,
  input  logic [7:0] i2c_data_in,
  input  logic       i2c_write_en,
  input  logic       i2c_read_en,
  output logic [7:0] reg_data_out,
  output logic       tick_1hz,
  output logic       alarm_irq
);

  localparam logic ALARM_ON = (ALARM_EN != 0);

  logic [6:0] sec_q, sec_t, sec_d, min_q, min_t, min_d, asec_q, asec_d, amin_q, amin_d;
  logic [5:0] hour_q, hour_t, hour_d, date_q, date_t, date_d, ahour_q, ahour_d, dim_s;
  logic [4:0] month_q, month_t, month_d;
  logic [2:0] day_q, day_t, day_d, ctrl_q, ctrl_d;
  logic [7:0] year_q, year_t, year_d, rd_mux_s, rdata_q, rdata_d;
  logic       af_q, af_d, irq_q, irq_d, tick_q, tick_s, alarm_hit_s;
  logic       c_min_s, c_hour_s, c_day_s, c_month_s, c_year_s;

  rtc_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .halt_i  (ctrl_q[CTRL_HALT]),
    .clear_i (i2c_write_en && (i2c_addr == ADDR_SEC)),
    .tick_o  (tick_s)
  );

  // Carry chain on a tick, computed from pre-edge values so writes only override their own field.
  always_comb begin
    sec_t = sec_q; min_t = min_q; hour_t = hour_q; day_t = day_q;
    date_t = date_q; month_t = month_q; year_t = year_q;
    c_min_s = 1'b0; c_hour_s = 1'b0; c_day_s = 1'b0; c_month_s = 1'b0; c_year_s = 1'b0;
    dim_s = days_in_month(month_q, year_q);
    if (tick_s) begin
      if (sec_q >= 7'h59) begin sec_t = 7'h00; c_min_s = 1'b1; end
      else begin sec_t = 7'(bcd_inc({1'b0, sec_q})); end
    end else begin
      sec_t = sec_q;
    end
    if (c_min_s) begin
      if (min_q >= 7'h59) begin min_t = 7'h00; c_hour_s = 1'b1; end
      else begin min_t = 7'(bcd_inc({1'b0, min_q})); end
    end else begin
      min_t = min_q;
    end
    if (c_hour_s) begin
      if (ctrl_q[CTRL_MODE12]) begin
        if (hour_q[4:0] == 5'h11) begin
          hour_t  = {~hour_q[5], 5'h12};
          c_day_s = hour_q[5];
        end else if (hour_q[4:0] >= 5'h12) begin
          hour_t = {hour_q[5], 5'h01};
        end else begin
          hour_t = {hour_q[5], 5'(bcd_inc({3'b000, hour_q[4:0]}))};
        end
      end else if (hour_q >= 6'h23) begin
        hour_t = 6'h00; c_day_s = 1'b1;
      end else begin
        hour_t = 6'(bcd_inc({2'b00, hour_q}));
      end
    end else begin
      hour_t = hour_q;
    end
    if (c_day_s) begin
      day_t = (day_q >= 3'd7) ? 3'd1 : day_q + 3'd1;
      if (date_q >= dim_s) begin date_t = 6'h01; c_month_s = 1'b1; end
      else begin date_t = 6'(bcd_inc({2'b00, date_q})); end
    end else begin
      day_t = day_q; date_t = date_q;
    end
    if (c_month_s) begin
      if (month_q >= 5'h12) begin month_t = 5'h01; c_year_s = 1'b1; end
      else begin month_t = 5'(bcd_inc({3'b000, month_q})); end
    end else begin
      month_t = month_q;
    end
    if (c_year_s) begin
      year_t = (year_q >= 8'h99) ? 8'h00 : bcd_inc(year_q);
    end else begin
      year_t = year_q;
    end
  end

  // Register writes override ticked values; AF set by a matching tick beats a same-cycle clear.
  always_comb begin
    sec_d = sec_t; min_d = min_t; hour_d = hour_t; day_d = day_t;
    date_d = date_t; month_d = month_t; year_d = year_t; ctrl_d = ctrl_q;
    asec_d = asec_q; amin_d = amin_q; ahour_d = ahour_q;
    if (i2c_write_en) begin
      case (i2c_addr)
        ADDR_SEC:   sec_d   = i2c_data_in[6:0];
        ADDR_MIN:   min_d   = i2c_data_in[6:0];
        ADDR_HOUR:  hour_d  = i2c_data_in[5:0];
        ADDR_DAY:   day_d   = i2c_data_in[2:0];
        ADDR_DATE:  date_d  = i2c_data_in[5:0];
        ADDR_MONTH: month_d = i2c_data_in[4:0];
        ADDR_YEAR:  year_d  = i2c_data_in;
        ADDR_CTRL:  ctrl_d  = i2c_data_in[2:0];
        ADDR_ASEC:  asec_d  = ALARM_ON ? i2c_data_in[6:0] : 7'h00;
        ADDR_AMIN:  amin_d  = ALARM_ON ? i2c_data_in[6:0] : 7'h00;
        ADDR_AHOUR: ahour_d = ALARM_ON ? i2c_data_in[5:0] : 6'h00;
        default:    ctrl_d  = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
    alarm_hit_s = ALARM_ON && tick_s && (sec_d == asec_q) && (min_d == amin_q) && (hour_d == ahour_q);
    if (alarm_hit_s) begin
      af_d = 1'b1;
    end else if (i2c_write_en && (i2c_addr == ADDR_STATUS) && i2c_data_in[STATUS_AF]) begin
      af_d = 1'b0;
    end else begin
      af_d = af_q;
    end
    irq_d = ALARM_ON && af_d && ctrl_d[CTRL_AIE];
  end

  always_comb begin
    case (i2c_addr)
      ADDR_SEC:    rd_mux_s = {1'b0, sec_q};
      ADDR_MIN:    rd_mux_s = {1'b0, min_q};
      ADDR_HOUR:   rd_mux_s = {2'b00, hour_q};
      ADDR_DAY:    rd_mux_s = {5'b00000, day_q};
      ADDR_DATE:   rd_mux_s = {2'b00, date_q};
      ADDR_MONTH:  rd_mux_s = {3'b000, month_q};
      ADDR_YEAR:   rd_mux_s = year_q;
      ADDR_CTRL:   rd_mux_s = {5'b00000, ctrl_q};
      ADDR_ASEC:   rd_mux_s = {1'b0, asec_q};
      ADDR_AMIN:   rd_mux_s = {1'b0, amin_q};
      ADDR_AHOUR:  rd_mux_s = {2'b00, ahour_q};
      ADDR_STATUS: rd_mux_s = {7'h00, af_q};
      default:     rd_mux_s = 8'h00;
    endcase
    rdata_d = i2c_read_en ? rd_mux_s : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q <= RST_SEC; min_q <= RST_MIN; hour_q <= RST_HOUR; day_q <= RST_DAY;
      date_q <= RST_DATE; month_q <= RST_MONTH; year_q <= RST_YEAR; ctrl_q <= RST_CTRL;
      asec_q <= 7'h00; amin_q <= 7'h00; ahour_q <= 6'h00; af_q <= 1'b0;
      rdata_q <= 8'h00; tick_q <= 1'b0; irq_q <= 1'b0;
    end else begin
      sec_q <= sec_d; min_q <= min_d; hour_q <= hour_d; day_q <= day_d;
      date_q <= date_d; month_q <= month_d; year_q <= year_d; ctrl_q <= ctrl_d;
      asec_q <= asec_d; amin_q <= amin_d; ahour_q <= ahour_d; af_q <= af_d;
      rdata_q <= rdata_d; tick_q <= tick_s; irq_q <= irq_d;
    end
  end

  assign reg_data_out = rdata_q;
  assign tick_1hz     = tick_q;
  assign alarm_irq    = irq_q;

endmodule

// File: tb/tb_rtc_core.sv
// Directed-vector bench for rtc_core with a 10-cycle second.
module tb_rtc_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i2c_addr;
  logic [7:0] i2c_data_in;
  logic       i2c_write_en;
  logic       i2c_read_en;
  logic [7:0] reg_data_out;
  logic       tick_1hz;
  logic       alarm_irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] lp_year  [5] = '{8'h23, 8'h24, 8'h00, 8'h23, 8'h23};
  logic [7:0] lp_mon   [5] = '{8'h02, 8'h02, 8'h02, 8'h04, 8'h01};
  logic [7:0] lp_date  [5] = '{8'h28, 8'h28, 8'h28, 8'h30, 8'h30};
  logic [7:0] lp_edate [5] = '{8'h01, 8'h29, 8'h29, 8'h01, 8'h31};
  logic [7:0] lp_emon  [5] = '{8'h03, 8'h02, 8'h02, 8'h05, 8'h01};
  logic [7:0] h12_in   [3] = '{8'h11, 8'h32, 8'h31};
  logic [7:0] h12_exp  [3] = '{8'h32, 8'h21, 8'h12};
  logic [7:0] h12_date [3] = '{8'h01, 8'h01, 8'h02};
  logic [7:0] rst_vals [8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};

  rtc_core #(.CLK_DIV(10), .ALARM_EN(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .i2c_addr     (i2c_addr),
    .i2c_data_in  (i2c_data_in),
    .i2c_write_en (i2c_write_en),
    .i2c_read_en  (i2c_read_en),
    .reg_data_out (reg_data_out),
    .tick_1hz     (tick_1hz),
    .alarm_irq    (alarm_irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; i2c_write_en = 1'b0; i2c_read_en = 1'b0;
    i2c_addr = 4'h0; i2c_data_in = 8'h00;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    i2c_addr = a; i2c_data_in = d; i2c_write_en = 1'b1;
    @(negedge clk);
    i2c_write_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    i2c_addr = a; i2c_read_en = 1'b1;
    @(negedge clk);
    i2c_read_en = 1'b0;
    d = reg_data_out;
  endtask

  task automatic wait_tick();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tick_1hz) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("tick_seen", {7'h00, seen}, 8'h01);
  endtask

  task automatic set_time(input logic [7:0] mode, input logic [7:0] yr, input logic [7:0] mo,
                          input logic [7:0] dt, input logic [7:0] hr, input logic [7:0] mi,
                          input logic [7:0] se);
    wr(4'h7, mode | 8'h01);
    wr(4'h6, yr); wr(4'h5, mo); wr(4'h4, dt); wr(4'h2, hr); wr(4'h1, mi); wr(4'h0, se);
  endtask

  task automatic run_tick(input logic [7:0] mode);
    wr(4'h7, mode);
    wait_tick();
    wr(4'h7, mode | 8'h01);
    check_eq("tick_width", {7'h00, tick_1hz}, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    int cnt;

    // Reset values across the map, unused addresses read zero and ignore writes.
    do_reset();
    check_eq("rst_rdata", reg_data_out, 8'h00);
    check_eq("rst_tick", {7'h00, tick_1hz}, 8'h00);
    check_eq("rst_irq", {7'h00, alarm_irq}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd(4'(i), d); check_eq("rst_reg", d, rst_vals[i]);
    end
    do_reset();
    for (int i = 8; i < 13; i++) begin
      rd(4'(i), d); check_eq("rst_reg_hi", d, 8'h00);
    end
    wr(4'hC, 8'hFF); rd(4'hC, d); check_eq("unused_addr", d, 8'h00);

    // Full rollover of every field.
    do_reset();
    set_time(8'h00, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    run_tick(8'h00);
    rd(4'h0, d); check_eq("roll_sec", d, 8'h00);
    rd(4'h1, d); check_eq("roll_min", d, 8'h00);
    rd(4'h2, d); check_eq("roll_hour", d, 8'h00);
    rd(4'h3, d); check_eq("roll_day", d, 8'h02);
    rd(4'h4, d); check_eq("roll_date", d, 8'h01);
    rd(4'h5, d); check_eq("roll_month", d, 8'h01);
    rd(4'h6, d); check_eq("roll_year", d, 8'h00);

    // Month lengths and leap years.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      set_time(8'h00, lp_year[i], lp_mon[i], lp_date[i], 8'h23, 8'h59, 8'h59);
      run_tick(8'h00);
      rd(4'h4, d); check_eq("leap_date", d, lp_edate[i]);
      rd(4'h5, d); check_eq("leap_month", d, lp_emon[i]);
    end

    // 12-hour stepping and the 11 PM -> 12 AM day carry.
    for (int i = 0; i < 3; i++) begin
      do_reset();
      set_time(8'h02, 8'h00, 8'h01, 8'h01, h12_in[i], 8'h59, 8'h59);
      run_tick(8'h02);
      rd(4'h2, d); check_eq("h12_hour", d, h12_exp[i]);
      rd(4'h4, d); check_eq("h12_date", d, h12_date[i]);
    end

    // Alarm at 00:00:05 from reset, then clear through STATUS.
    do_reset();
    wr(4'h8, 8'h05); wr(4'h9, 8'h00); wr(4'hA, 8'h00); wr(4'h7, 8'h04);
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      check_eq("alarm_irq_tick", {7'h00, alarm_irq}, (k == 5) ? 8'h01 : 8'h00);
    end
    rd(4'hB, d); check_eq("status_af", d, 8'h01);
    wr(4'hB, 8'h00); check_eq("irq_hold", {7'h00, alarm_irq}, 8'h01);
    wr(4'hB, 8'h01); check_eq("irq_clear", {7'h00, alarm_irq}, 8'h00);
    rd(4'hB, d); check_eq("status_clr", d, 8'h00);

    // Halt freezes time; reset mid-count restarts everything.
    do_reset();
    wr(4'h0, 8'h10); wr(4'h7, 8'h01);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (tick_1hz) cnt++;
    end
    check_eq("halt_ticks", 8'(cnt), 8'h00);
    rd(4'h0, d); check_eq("halt_sec", d, 8'h10);
    wr(4'h7, 8'h00);
    repeat (4) @(negedge clk);
    rd(4'h0, d); check_eq("pre_rst_sec", d, 8'h10);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rdata", reg_data_out, 8'h00);
    check_eq("mid_rst_tick", {7'h00, tick_1hz}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(4'(i), d); check_eq("mid_rst_reg", d, rst_vals[i]);
    end
    cnt = 8;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (tick_1hz) break;
    end
    check_eq("first_tick_delay", 8'(cnt), 8'd10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
